// File: rtl/i2c_seq_pkg.sv
// Shared types for the I2C command sequencer: FSM states, response status codes
// and the descriptor size check.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ABORT,
    RESP
  } seq_state_e;

  localparam logic [1:0] ST_OK_WR   = 2'd0;
  localparam logic [1:0] ST_OK_RD   = 2'd1;
  localparam logic [1:0] ST_ERR     = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [1:0] status;
    logic [7:0] data;
  } seq_rsp_t;

  // A transfer must move at least one byte and fit the master's data buffer.
  function automatic logic size_in_range(input logic [7:0] size, input int max_bytes);
    return (size != 8'd0) && (int'(size) <= max_bytes);
  endfunction

endpackage

// File: rtl/i2c_seq_timer.sv
// Saturating WAIT-state watchdog; expired asserts once TIMEOUT_CYCLES-1 enabled
// cycles have elapsed since the last clear.
module i2c_seq_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && (count != CW'(TIMEOUT_CYCLES)))
      count <= count + 1'b1;
  end

  assign expired = (count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Sequencer in front of the I2C master: accepts one descriptor, runs it on the
// master with a timeout/abort path, and returns exactly one response per command.
module i2c_cmd_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int ABORT_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_addr,
  input  logic [DATA_WIDTH*8-1:0] cmd_data,
  input  logic [7:0]              cmd_size,
  input  logic [15:0]             cmd_prescaler,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    m_start_i2c,
  output logic                    m_i2c_en,
  output logic                    m_int_en,
  output logic [7:0]              m_addr,
  output logic [DATA_WIDTH*8-1:0] m_data_to_send,
  output logic [7:0]              m_data_size,
  output logic [15:0]             m_prescaler,
  input  logic                    m_valid_trans,
  input  logic                    m_valid_recep,
  input  logic                    m_error,
  input  logic [7:0]              m_data_received
);

  localparam int AW = (ABORT_CYCLES > 1) ? $clog2(ABORT_CYCLES) : 1;

  seq_state_e    state, state_n;
  seq_rsp_t      rsp_q, rsp_n;
  logic [AW-1:0] abort_cnt, abort_cnt_n;
  logic          cmd_ready_n, rsp_valid_n, start_n, en_n;
  logic          trans_q, recep_q, error_q;
  logic          trans_rise, recep_rise, error_rise;
  logic          cmd_fire, rsp_fire, expired;

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign trans_rise = m_valid_trans && !trans_q;
  assign recep_rise = m_valid_recep && !recep_q;
  assign error_rise = m_error && !error_q;

  assign rsp_data   = rsp_q.data;
  assign rsp_status = rsp_q.status;
  assign m_int_en   = 1'b0;

  i2c_seq_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == START),
    .enable (state == WAIT),
    .expired(expired)
  );

  always_comb begin
    state_n     = state;
    rsp_n       = rsp_q;
    abort_cnt_n = abort_cnt;
    cmd_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
    start_n     = 1'b0;
    en_n        = m_i2c_en;
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_fire) begin
          cmd_ready_n = 1'b0;
          if (size_in_range(cmd_size, DATA_WIDTH)) begin
            state_n = START;
            en_n    = 1'b1;
          end else begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_n       = '{status: ST_ERR, data: 8'h00};
          end
        end
      end
      // Two cycles: the first arms the registered pulse, the second emits it.
      START: begin
        en_n = 1'b1;
        if (!m_start_i2c)
          start_n = 1'b1;
        else
          state_n = WAIT;
      end
      WAIT: begin
        if (error_rise || recep_rise || trans_rise) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          if (error_rise)
            rsp_n = '{status: ST_ERR, data: 8'h00};
          else if (recep_rise)
            rsp_n = '{status: ST_OK_RD, data: m_data_received};
          else
            rsp_n = '{status: ST_OK_WR, data: 8'h00};
        end else if (expired) begin
          state_n     = ABORT;
          en_n        = 1'b0;
          abort_cnt_n = '0;
        end
      end
      ABORT: begin
        en_n = 1'b0;
        if (abort_cnt == AW'(ABORT_CYCLES - 1)) begin
          state_n     = RESP;
          rsp_valid_n = 1'b1;
          rsp_n       = '{status: ST_TIMEOUT, data: 8'h00};
        end else begin
          abort_cnt_n = abort_cnt + 1'b1;
        end
      end
      RESP: begin
        rsp_valid_n = 1'b1;
        if (rsp_fire) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          en_n        = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rsp_q          <= '0;
      abort_cnt      <= '0;
      cmd_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      m_start_i2c    <= 1'b0;
      m_i2c_en       <= 1'b0;
      m_addr         <= '0;
      m_data_to_send <= '0;
      m_data_size    <= '0;
      m_prescaler    <= '0;
      trans_q        <= 1'b0;
      recep_q        <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state       <= state_n;
      rsp_q       <= rsp_n;
      abort_cnt   <= abort_cnt_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      m_start_i2c <= start_n;
      m_i2c_en    <= en_n;
      trans_q     <= m_valid_trans;
      recep_q     <= m_valid_recep;
      error_q     <= m_error;
      if (cmd_fire) begin
        m_addr         <= cmd_addr;
        m_data_to_send <= cmd_data;
        m_data_size    <= cmd_size;
        m_prescaler    <= cmd_prescaler;
      end
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer: cycle-accurate checks in one initial block
// plus a response scoreboard popped on every response handshake.
module tb_i2c_cmd_sequencer;
  import i2c_seq_pkg::*;

  localparam int DW = 9;
  localparam int TO = 300;
  localparam int AB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [7:0]      cmd_addr = '0, cmd_size = '0;
  logic [DW*8-1:0] cmd_data = '0;
  logic [15:0]     cmd_prescaler = '0;
  logic            rsp_valid, rsp_ready = 1'b1;
  logic [7:0]      rsp_data;
  logic [1:0]      rsp_status;
  logic            m_start_i2c, m_i2c_en, m_int_en;
  logic [7:0]      m_addr, m_data_size;
  logic [DW*8-1:0] m_data_to_send;
  logic [15:0]     m_prescaler;
  logic            m_valid_trans = 1'b0, m_valid_recep = 1'b0, m_error = 1'b0;
  logic [7:0]      m_data_received = '0;

  int checks = 0, failures = 0, starts = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .ABORT_CYCLES(AB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_size(cmd_size), .cmd_prescaler(cmd_prescaler),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .m_start_i2c(m_start_i2c), .m_i2c_en(m_i2c_en), .m_int_en(m_int_en),
    .m_addr(m_addr), .m_data_to_send(m_data_to_send), .m_data_size(m_data_size),
    .m_prescaler(m_prescaler), .m_valid_trans(m_valid_trans), .m_valid_recep(m_valid_recep),
    .m_error(m_error), .m_data_received(m_data_received)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pop on each response handshake; also counts start pulses.
  always @(negedge clk) begin
    if (m_start_i2c === 1'b1) starts++;
    if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0) chk("sb_rsp", 128'({rsp_status, rsp_data}), 128'(sb.pop_front()));
    end
  end

  // Leaves the bench at T+1 of the accepted command.
  task automatic send(input logic [7:0] a, input logic [DW*8-1:0] d, input logic [7:0] sz,
                      input logic [15:0] p, input logic [1:0] st, input logic [7:0] dat);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("cmd_ready_wait", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_size = sz; cmd_prescaler = p;
    sb.push_back({st, dat});
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_T1", 128'(cmd_ready), 128'(0));
    chk("m_addr", 128'(m_addr), 128'(a));
    chk("m_data_to_send", 128'(m_data_to_send), 128'(d));
    chk("m_data_size", 128'(m_data_size), 128'(sz));
    chk("m_prescaler", 128'(m_prescaler), 128'(p));
  endtask

  // From T+1 to T+3 (first WAIT cycle), checking enable and the single start pulse.
  task automatic go_wait();
    chk("en_T1", 128'(m_i2c_en), 128'(1));
    chk("start_T1", 128'(m_start_i2c), 128'(0));
    tick();
    chk("start_T2", 128'(m_start_i2c), 128'(1));
    tick();
    chk("start_T3", 128'(m_start_i2c), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic bad;
    repeat (3) tick();
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_en", 128'(m_i2c_en), 128'(0));
    chk("rst_int_en", 128'(m_int_en), 128'(0));
    chk("rst_m_addr", 128'(m_addr), 128'(0));
    rst = 1'b0;
    tick();
    chk("ready_after_rst", 128'(cmd_ready), 128'(1));

    // Write, completion 200 cycles after the start pulse
    send(8'h50, 72'h22110A, 8'd3, 16'h0031, ST_OK_WR, 8'h00);
    go_wait();
    bad = 1'b0;
    repeat (199) begin
      tick();
      if (rsp_valid !== 1'b0 || m_i2c_en !== 1'b1) bad = 1'b1;
    end
    m_valid_trans = 1'b1;
    tick();
    chk("wr_hold", 128'(bad), 128'(0));
    chk("wr_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("wr_status", 128'(rsp_status), 128'(ST_OK_WR));
    chk("wr_data", 128'(rsp_data), 128'(0));
    chk("wr_en_R", 128'(m_i2c_en), 128'(1));
    tick();
    chk("wr_rsp_drop", 128'(rsp_valid), 128'(0));
    chk("wr_ready_back", 128'(cmd_ready), 128'(1));
    chk("wr_en_drop", 128'(m_i2c_en), 128'(0));

    // Read, with m_valid_trans left high from the previous write
    send(8'h51, 72'h0, 8'd1, 16'h0010, ST_OK_RD, 8'hA5);
    go_wait();
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    chk("stale_trans", 128'(bad), 128'(0));
    m_data_received = 8'hA5; m_valid_recep = 1'b1;
    tick();
    chk("rd_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("rd_status", 128'(rsp_status), 128'(ST_OK_RD));
    chk("rd_data", 128'(rsp_data), 128'(8'hA5));
    tick();
    m_valid_trans = 1'b0; m_valid_recep = 1'b0;

    // Error and trans rising together
    send(8'h50, 72'h3344, 8'd2, 16'h0010, ST_ERR, 8'h00);
    go_wait();
    repeat (10) tick();
    m_error = 1'b1; m_valid_trans = 1'b1;
    tick();
    chk("err_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("err_status", 128'(rsp_status), 128'(ST_ERR));
    chk("err_data", 128'(rsp_data), 128'(0));
    tick();
    m_error = 1'b0; m_valid_trans = 1'b0;

    // Size 0 rejected without bus activity
    s0 = starts;
    send(8'h50, 72'h1, 8'd0, 16'h0010, ST_ERR, 8'h00);
    chk("sz0_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("sz0_status", 128'(rsp_status), 128'(ST_ERR));
    chk("sz0_en", 128'(m_i2c_en), 128'(0));
    tick();
    chk("sz0_ready_back", 128'(cmd_ready), 128'(1));

    // Size 10 rejected, response held under 50 cycles of backpressure
    rsp_ready = 1'b0;
    send(8'h50, 72'h2, 8'd10, 16'h0010, ST_ERR, 8'h00);
    chk("sz10_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("sz10_status", 128'(rsp_status), 128'(ST_ERR));
    bad = 1'b0;
    repeat (50) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_status !== ST_ERR || rsp_data !== 8'h00 ||
          cmd_ready !== 1'b0 || m_start_i2c !== 1'b0) bad = 1'b1;
    end
    chk("bp_stable", 128'(bad), 128'(0));
    rsp_ready = 1'b1;
    tick();
    chk("bp_rsp_drop", 128'(rsp_valid), 128'(0));
    chk("bp_ready_back", 128'(cmd_ready), 128'(1));
    chk("reject_no_start", 128'(starts), 128'(s0));

    // Timeout: last WAIT cycle at T+3+TO-1, then AB abort cycles with enable low
    send(8'h50, 72'h5, 8'd1, 16'h0010, ST_TIMEOUT, 8'h00);
    go_wait();
    repeat (TO - 1) tick();
    chk("to_en_expiry", 128'(m_i2c_en), 128'(1));
    chk("to_rsp_expiry", 128'(rsp_valid), 128'(0));
    bad = 1'b0;
    repeat (AB) begin
      tick();
      if (m_i2c_en !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
    end
    chk("to_abort_low", 128'(bad), 128'(0));
    tick();
    chk("to_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("to_status", 128'(rsp_status), 128'(ST_TIMEOUT));
    chk("to_en", 128'(m_i2c_en), 128'(0));
    tick();

    // Completion on the expiry cycle wins over the timeout
    send(8'h50, 72'h6, 8'd1, 16'h0010, ST_OK_WR, 8'h00);
    go_wait();
    repeat (TO - 1) tick();
    m_valid_trans = 1'b1;
    tick();
    chk("tc_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("tc_status", 128'(rsp_status), 128'(ST_OK_WR));
    chk("tc_en", 128'(m_i2c_en), 128'(1));
    tick();
    m_valid_trans = 1'b0;

    // Reset in WAIT discards the pending response
    send(8'h50, 72'h7, 8'd1, 16'h0010, ST_OK_WR, 8'h00);
    go_wait();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    sb.delete();
    chk("mid_rst_outputs", 128'({cmd_ready, rsp_valid, rsp_data, rsp_status, m_start_i2c, m_i2c_en,
                                 m_addr, m_data_size, m_prescaler}), 128'(0));
    chk("mid_rst_data", 128'(m_data_to_send), 128'(0));
    rst = 1'b0;
    tick();
    chk("mid_rst_ready", 128'(cmd_ready), 128'(1));
    repeat (5) tick();
    chk("mid_rst_no_rsp", 128'(rsp_valid), 128'(0));

    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("start_count", 128'(starts), 128'(6));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
